// File: rtl/ram_burst_reader.sv
// Burst reader: streams count_i consecutive words from a single-port RAM with one-cycle read
// latency into a 2-entry output buffer under valid/ready flow control.
module ram_burst_reader #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  input  logic [ADDR_WIDTH-1:0]  base_addr_i,
  input  logic [COUNT_WIDTH-1:0] count_i,
  output logic [ADDR_WIDTH-1:0]  ram_addr_o,
  output logic                   ram_we_o,
  output logic [DATA_WIDTH-1:0]  ram_data_o,
  input  logic [DATA_WIDTH-1:0]  ram_q_i,
  output logic [DATA_WIDTH-1:0]  data_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   last_o,
  output logic                   busy_o,
  output logic                   done_o
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain} state_e;

  localparam logic [COUNT_WIDTH-1:0] CntOne = COUNT_WIDTH'(1);

  state_e                 r_state;
  logic [ADDR_WIDTH-1:0]  r_base;
  logic [COUNT_WIDTH-1:0] r_count;
  logic [COUNT_WIDTH-1:0] r_issued;
  logic [COUNT_WIDTH-1:0] r_popped;
  logic                   r_inflight;
  logic [ADDR_WIDTH-1:0]  r_last_addr;
  logic [DATA_WIDTH-1:0]  r_buf [2];
  logic                   r_rd_ptr;
  logic                   r_wr_ptr;
  logic [1:0]             r_occ;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_pop;
  logic [2:0]             w_slots;
  logic                   w_issue;
  logic                   w_last_issue;
  logic [ADDR_WIDTH-1:0]  w_issue_addr;

  assign valid_o    = (r_occ != 2'd0);
  assign data_o     = r_buf[r_rd_ptr];
  assign last_o     = valid_o && (r_popped == r_count - CntOne);
  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign ram_we_o   = 1'b0;
  assign ram_data_o = '0;

  assign w_pop        = valid_o & ready_i;
  // Words held or promised after this edge; a new read may only go out if one slot stays free.
  assign w_slots      = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_issue      = (r_state == StRead) && (r_issued != r_count) && (w_slots < 3'd2);
  assign w_last_issue = w_issue && (r_issued == r_count - CntOne);
  assign w_issue_addr = r_base + ADDR_WIDTH'(r_issued);
  // The address is presented during the issuing cycle so the RAM samples it at the next edge.
  assign ram_addr_o   = w_issue ? w_issue_addr : r_last_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_base      <= '0;
      r_count     <= '0;
      r_issued    <= '0;
      r_popped    <= '0;
      r_inflight  <= 1'b0;
      r_last_addr <= '0;
      r_buf[0]    <= '0;
      r_buf[1]    <= '0;
      r_rd_ptr    <= 1'b0;
      r_wr_ptr    <= 1'b0;
      r_occ       <= 2'd0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      r_occ      <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
      if (r_inflight) begin
        r_buf[r_wr_ptr] <= ram_q_i;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_popped <= r_popped + CntOne;
      end
      if (w_issue) begin
        r_last_addr <= w_issue_addr;
        r_issued    <= r_issued + CntOne;
      end
      unique case (r_state)
        StIdle: begin
          if (start_i) begin
            if (count_i != '0) begin
              r_base   <= base_addr_i;
              r_count  <= count_i;
              r_issued <= '0;
              r_popped <= '0;
              r_busy   <= 1'b1;
              r_state  <= StRead;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        StRead: begin
          if (w_last_issue) r_state <= StDrain;
        end
        StDrain: begin
          if (w_pop && last_o) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Randomized bench for ram_burst_reader: a behavioural RAM plus a queue-based model of the
// expected word stream, checked against valid/ready transfers, last/done/busy and addresses.
module tb_ram_burst_reader;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int CW = 6;
  localparam int MemWords = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start_i;
  logic [AW-1:0] base_addr_i;
  logic [CW-1:0] count_i;
  logic [AW-1:0] ram_addr_o;
  logic          ram_we_o;
  logic [DW-1:0] ram_data_o;
  logic [DW-1:0] ram_q_i;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i;
  logic          last_o;
  logic          busy_o;
  logic          done_o;

  logic [DW-1:0] mem [MemWords];
  logic [DW-1:0] r_q;

  int n_cmp = 0;
  int n_bad = 0;

  ram_burst_reader #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start_i    (start_i),
    .base_addr_i(base_addr_i),
    .count_i    (count_i),
    .ram_addr_o (ram_addr_o),
    .ram_we_o   (ram_we_o),
    .ram_data_o (ram_data_o),
    .ram_q_i    (ram_q_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .ready_i    (ready_i),
    .last_o     (last_o),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk = ~clk;

  // Single-port RAM with registered read data.
  always @(posedge clk) r_q <= mem[ram_addr_o];
  assign ram_q_i = r_q;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // mode 0: ready held high; 1: ready toggles; 2: random ready + junk starts; 3: stall 10 cycles
  task automatic run_burst(input int base, input int cnt, input int mode);
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] pd;
    logic [AW-1:0] addr0;
    logic          pv;
    logic          pr;
    int            idx;
    int            k;
    int            first_v;
    bit            fin;
    idx = 0; k = 0; first_v = -1; fin = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    for (int i = 0; i < cnt; i++) exp_q.push_back(mem[(base + i) % MemWords]);
    addr0       = ram_addr_o;
    start_i     = 1'b1;
    base_addr_i = AW'(base);
    count_i     = CW'(cnt);
    @(posedge clk);
    while (!fin) begin
      #1;
      case (mode)
        0:       ready_i = 1'b1;
        1:       ready_i = (k % 2 == 0);
        2:       ready_i = ($urandom % 3 != 0);
        default: ready_i = (k >= 10);
      endcase
      start_i     = (mode == 2) ? 1'($urandom % 2) : 1'b0;
      base_addr_i = AW'($urandom);
      count_i     = CW'($urandom);
      @(negedge clk);
      if (k == 0) begin
        check_eq("busy_after_start", 32'(busy_o), 32'(cnt != 0));
        if (cnt != 0) check_eq("done_low_in_burst", 32'(done_o), 0);
      end
      if (pv && !pr) begin
        check_eq("valid_held", 32'(valid_o), 1);
        check_eq("data_stable", data_o, pd);
      end
      if (valid_o && first_v < 0) first_v = k;
      if (mode == 0 && k < cnt) check_eq("addr_seq", 32'(ram_addr_o), 32'((base + k) % MemWords));
      if (cnt == 0) begin
        check_eq("zero_addr_held", 32'(ram_addr_o), 32'(addr0));
        check_eq("zero_no_valid", 32'(valid_o), 0);
      end
      if (mode == 3 && k == 9 && cnt >= 3) begin
        check_eq("stall_valid", 32'(valid_o), 1);
        check_eq("stall_head", data_o, exp_q[0]);
        check_eq("stall_two_reads", 32'(ram_addr_o), 32'((base + 1) % MemWords));
      end
      if (valid_o && ready_i) begin
        if (idx < cnt) begin
          check_eq("word", data_o, exp_q[idx]);
          check_eq("last_flag", 32'(last_o), 32'(idx == cnt - 1));
        end else begin
          check_eq("extra_word", 32'(idx), 32'(cnt - 1));
        end
        idx++;
      end else if (valid_o) begin
        check_eq("last_flag_stalled", 32'(last_o), 32'(idx == cnt - 1));
      end
      if (done_o) begin
        check_eq("words_at_done", 32'(idx), 32'(cnt));
        check_eq("busy_at_done", 32'(busy_o), 0);
        if (mode == 0 && cnt != 0) begin
          check_eq("first_latency", 32'(first_v), 2);
          check_eq("throughput", 32'(k), 32'(cnt + 2));
        end
        start_i = 1'b0;
        fin = 1;
      end else if (k > 4 * cnt + 30) begin
        check_eq("done_timeout", 32'(done_o), 1);
        start_i = 1'b0;
        fin = 1;
      end
      pv = valid_o; pr = ready_i; pd = data_o;
      k++;
      if (!fin) @(posedge clk);
    end
  endtask

  task automatic preload_fixed();
    for (int i = 0; i < MemWords; i++) mem[i] = 32'h0;
    mem[0] = 32'hFFFFFFFF;
    mem[2] = 32'h12345678;
    mem[3] = 32'h98761234;
    mem[4] = 32'hA0A0A0A0;
  endtask

  initial begin
    int xfers;
    reset = 1'b1; start_i = 1'b0; ready_i = 1'b0; base_addr_i = '0; count_i = '0;
    preload_fixed();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 32'(valid_o), 0);
    check_eq("rst_busy", 32'(busy_o), 0);
    check_eq("rst_done", 32'(done_o), 0);
    check_eq("rst_last", 32'(last_o), 0);
    check_eq("rst_addr", 32'(ram_addr_o), 0);
    check_eq("rst_we", 32'(ram_we_o), 0);
    check_eq("rst_wdata", ram_data_o, 0);

    run_burst(2, 3, 0);
    run_burst(2, 3, 1);
    run_burst(2, 5, 3);
    run_burst(30, 4, 0);
    run_burst(7, 0, 0);
    run_burst(3, 2, 0);

    // Reset mid-burst: no done pulse, everything cleared.
    start_i = 1'b1; base_addr_i = AW'(2); count_i = CW'(6);
    @(posedge clk);
    #1 start_i = 1'b0; ready_i = 1'b1;
    xfers = 0;
    for (int c = 0; c < 20 && xfers < 2; c++) begin
      @(negedge clk);
      if (valid_o && ready_i) xfers++;
      if (xfers < 2) @(posedge clk);
    end
    check_eq("mid_burst_xfers", 32'(xfers), 2);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("mrst_valid", 32'(valid_o), 0);
    check_eq("mrst_last", 32'(last_o), 0);
    check_eq("mrst_busy", 32'(busy_o), 0);
    check_eq("mrst_done", 32'(done_o), 0);
    check_eq("mrst_addr", 32'(ram_addr_o), 0);
    @(negedge clk);
    check_eq("mrst_no_done", 32'(done_o), 0);
    check_eq("mrst_no_valid", 32'(valid_o), 0);
    run_burst(0, 1, 0);

    for (int i = 0; i < MemWords; i++) mem[i] = $urandom;
    for (int t = 0; t < 25; t++) begin
      run_burst(int'($urandom_range(0, MemWords - 1)), int'($urandom_range(0, 12)),
                int'($urandom_range(0, 3)));
    end
    run_burst(int'($urandom_range(0, MemWords - 1)), (1 << CW) - 1, 2);
    run_burst(int'($urandom_range(0, MemWords - 1)), (1 << CW) - 1, 0);

    ready_i = 1'b0;
    @(negedge clk);
    check_eq("done_single_pulse", 32'(done_o), 0);
    check_eq("idle_busy", 32'(busy_o), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_burst_reader.md
RAM_BURST_READER -- requirements
Module: ram_burst_reader

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, word-address width of the RAM port.
REQ-002 Parameter DATA_WIDTH, default 32, RAM and stream data width.
REQ-003 Parameter COUNT_WIDTH, default 16, burst-length field width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 start_i  in  1  burst request, sampled only in IDLE.
REQ-007 base_addr_i  in  ADDR_WIDTH  first word address, captured with start_i.
REQ-008 count_i  in  COUNT_WIDTH  number of words, captured with start_i.
REQ-009 ram_addr_o  out  ADDR_WIDTH  address driven to the single_port_ram addr port.
REQ-010 ram_we_o  out  1  RAM write enable, tied 0.
REQ-011 ram_data_o  out  DATA_WIDTH  RAM write data, tied 0.
REQ-012 ram_q_i  in  DATA_WIDTH  RAM read data, valid one clock after the address is presented.
REQ-013 data_o  out  DATA_WIDTH  stream data, head of output buffer.
REQ-014 valid_o  out  1  data_o holds a word.
REQ-015 ready_i  in  1  consumer accepts; transfer when valid_o and ready_i are both high on a rising edge.
REQ-016 last_o  out  1  high with the final word of the burst.
REQ-017 busy_o  out  1  burst in progress.
REQ-018 done_o  out  1  one-cycle pulse at burst completion.

Function
REQ-019 FSM states IDLE, READ, DRAIN; reset state IDLE.
REQ-020 IDLE: start_i=1 and count_i!=0 -> capture base/count, go READ, busy_o=1 next cycle.
REQ-021 IDLE: start_i=1 and count_i=0 -> no RAM read, done_o pulses next cycle, busy_o stays 0.
REQ-022 start_i outside IDLE is ignored; captured base/count do not change.
REQ-023 Read issue in READ: remaining>0 and (occupancy + in-flight - pop) < 2, where pop = valid_o & ready_i this cycle.
REQ-024 An issued read drives ram_addr_o = base + issued_count (mod 2^ADDR_WIDTH, wrap from all-ones to 0), then increments issued_count.
REQ-025 At most one read in flight; the returned ram_q_i is written into the output buffer on the next rising edge.
REQ-026 Output buffer is a 2-entry FIFO; never overflows; word order equals address order.
REQ-027 Full throughput: with ready_i held 1, one word transferred per clock after a 2-cycle initial latency (start edge to first valid_o).
REQ-028 After the last read issues -> DRAIN; ram_addr_o holds its last value.
REQ-029 last_o = valid_o and head word is word count-1; last_o=0 otherwise.
REQ-030 Last word transferred -> done_o=1 for exactly the next cycle, busy_o=0 on that same cycle, state IDLE.
REQ-031 A start_i asserted in the done_o cycle is accepted (state already IDLE).
REQ-032 valid_o, once high, stays high with data_o stable until transferred.
REQ-033 count_i = 2^COUNT_WIDTH-1 is legal; internal counters are COUNT_WIDTH bits.

Reset
REQ-034 reset=1 at any rising edge forces IDLE; valid_o, last_o, busy_o, done_o, ram_addr_o, buffer occupancy, in-flight flag and counters are 0 next cycle.
REQ-035 Reset mid-burst discards buffered and in-flight words; no done_o pulse.
REQ-036 ram_we_o and ram_data_o are 0 in and out of reset.

Verification
REQ-037 RAM preloaded 0:FFFFFFFF, 2:12345678, 3:98761234, 4:A0A0A0A0; start base=2 count=3, ready_i=1 -> data_o 12345678, 98761234, A0A0A0A0 on consecutive cycles, last_o with A0A0A0A0, done_o next cycle.
REQ-038 Same burst, ready_i toggling 1/0 each cycle -> same 3 words in order, none duplicated or lost, data_o stable while stalled.
REQ-039 ready_i=0 for 10 cycles after start with count=5 -> exactly 2 reads issued, valid_o=1 with first word; release ready -> all 5 words delivered.
REQ-040 ADDR_WIDTH=5, base=30 count=4 -> ram_addr_o sequence 30, 31, 0, 1.
REQ-041 count=0 -> no ram_addr_o change, done_o single pulse, valid_o never high.
REQ-042 reset asserted after the 2nd word of a count=6 burst -> all outputs 0 next cycle, no done_o; fresh start base=0 count=1 -> FFFFFFFF with last_o.
